// File: rtl/alu_pkg.sv
// Shared opCode encodings, flag bit positions and the packed FIFO entry layout
// used by alu_result_capture and its storage FIFO.
package alu_pkg;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    localparam int unsigned ALU_DEFAULT_W = 4;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] flags;
    } alu_tag_t;

    // Reference layout at the default data width; the top rebuilds it at WIDTH.
    typedef struct packed {
        alu_tag_t                 tag;
        logic [ALU_DEFAULT_W-1:0] result;
    } alu_entry_t;

    function automatic logic [3:0] alu_flags(input logic v, input logic c,
                                             input logic n, input logic z);
        logic [3:0] f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_capture_sync_fifo.sv
// Show-ahead synchronous FIFO with registered empty/full and a registered write
// ready that stays low until the first clock after reset.
module sync_fifo #(
    parameter int unsigned W     = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [W-1:0]               wr_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [W-1:0]               rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          ready_q, ready_d;
    logic          push, pop;

    // ready_q mirrors !full_q but is held low through reset.
    assign push     = wr_valid && ready_q && !full_q;
    assign pop      = !empty_q && rd_ready;
    assign wr_ready = ready_q;
    assign rd_valid = !empty_q;
    assign rd_data  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
        ready_d = !full_d;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ready_q  <= ready_d;
        end
    end

endmodule

// File: rtl/alu_result_capture.sv
// Captures add/sub ALU results into a show-ahead FIFO with flags, sticky overflow
// and saturating op/drop statistics (statistics built only with ALU_CAPTURE_STATS_EN).
module alu_result_capture
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              opCode,
    input  logic [WIDTH-1:0]        add_Y,
    input  logic [WIDTH-1:0]        sub_Y,
    input  logic                    CarryOUT,
    input  logic                    overflow,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_result,
    output logic [3:0]              out_flags,
    output logic [1:0]              out_op,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    sticky_overflow,
    input  logic                    clear_sticky,
    output logic [CNT_W-1:0]        op_count,
    output logic [CNT_W-1:0]        drop_count
);

    typedef struct packed {
        alu_tag_t         tag;
        logic [WIDTH-1:0] result;
    } entry_t;

    entry_t           wr_entry, rd_entry;
    logic [WIDTH-1:0] result;
    logic             accept, op_ok, push, drop;
    logic             sticky_q, sticky_d;

    assign accept = in_valid && in_ready;
    assign op_ok  = (opCode == OP_ADD) || (opCode == OP_SUB);
    assign push   = accept && op_ok;
    assign drop   = accept && !op_ok;
    assign result = (opCode == OP_SUB) ? sub_Y : add_Y;

    always_comb begin
        wr_entry           = '0;
        wr_entry.tag.op    = opCode;
        wr_entry.tag.flags = alu_flags(overflow, CarryOUT, result[WIDTH-1], result == '0);
        wr_entry.result    = result;
    end

    sync_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (push),
        .wr_ready (in_ready),
        .wr_data  (wr_entry),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (rd_entry),
        .count    (fifo_count)
    );

    assign out_result = rd_entry.result;
    assign out_flags  = rd_entry.tag.flags;
    assign out_op     = rd_entry.tag.op;

    // Set is applied after clear so a same-cycle overflow beat wins.
    always_comb begin
        sticky_d = sticky_q;
        if (clear_sticky) sticky_d = 1'b0;
        if (push && overflow) sticky_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) sticky_q <= 1'b0;
        else       sticky_q <= sticky_d;
    end

    assign sticky_overflow = sticky_q;

`ifdef ALU_CAPTURE_STATS_EN
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;

    always_comb begin
        op_count_d   = op_count_q;
        drop_count_d = drop_count_q;
        if (push && (op_count_q != '1))   op_count_d   = op_count_q + CNT_W'(1);
        if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_count_q   <= '0;
            drop_count_q <= '0;
        end else begin
            op_count_q   <= op_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign op_count   = op_count_q;
    assign drop_count = drop_count_q;
`else
    assign op_count   = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_alu_result_capture.sv
// Scoreboard bench for alu_result_capture: directed beats push expected entries,
// a negedge monitor pops and compares every consumed FIFO head.
module tb_alu_result_capture;

`ifdef ALU_CAPTURE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, in_valid, in_ready, CarryOUT, overflow;
    logic [1:0] opCode, out_op;
    logic [3:0] add_Y, sub_Y, out_result, out_flags;
    logic       out_valid, out_ready, sticky_overflow, clear_sticky;
    logic [2:0] fifo_count;
    logic [7:0] op_count, drop_count;

    typedef struct {
        logic [1:0] op;
        logic [3:0] flags;
        logic [3:0] result;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_ops  = 0;
    int   n_drop = 0;

    always #5 clk = ~clk;

    alu_result_capture #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opCode(opCode), .add_Y(add_Y), .sub_Y(sub_Y), .CarryOUT(CarryOUT),
        .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_op(out_op),
        .fifo_count(fifo_count), .sticky_overflow(sticky_overflow),
        .clear_sticky(clear_sticky), .op_count(op_count), .drop_count(drop_count)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_result", int'(out_result), int'(e.result));
                chk("mon_flags", int'(out_flags), int'(e.flags));
                chk("mon_op", int'(out_op), int'(e.op));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic beat(input logic [1:0] op, input logic [3:0] a, input logic [3:0] s,
                        input logic c, input logic v);
        int   n;
        exp_t e;
        logic [3:0] r;
        n = 0;
        opCode = op; add_Y = a; sub_Y = s; CarryOUT = c; overflow = v; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        sync();
        in_valid = 1'b0;
        if (op == 2'b01 || op == 2'b10) begin
            r        = (op == 2'b01) ? a : s;
            e.op     = op;
            e.result = r;
            e.flags  = {v, c, r[3], (r == 4'd0)};
            exp_q.push_back(e);
            n_ops++;
        end else begin
            n_drop++;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(out_valid), 0);
        chk({name, "_queue"}, exp_q.size(), 0);
        sync();
    endtask

    function automatic int sat(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; opCode = 2'b00; add_Y = '0; sub_Y = '0;
        CarryOUT = 1'b0; overflow = 1'b0; out_ready = 1'b1; clear_sticky = 1'b0;
        repeat (2) sync();
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_sticky", int'(sticky_overflow), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        sync();
        reset = 1'b0;
        sync();
        chk("in_ready_after_reset", int'(in_ready), 1);

        // add 4+3
        beat(2'b01, 4'b0111, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        chk("add_latency_valid", int'(out_valid), 1);
        chk("add_result", int'(out_result), 7);
        chk("add_flags", int'(out_flags), 0);
        chk("op_count_1", int'(op_count), STATS ? 1 : 0);
        sync();

        // sub 6-2
        beat(2'b10, 4'b0000, 4'b0100, 1'b1, 1'b0);
        @(negedge clk);
        chk("sub_flags", int'(out_flags), 4'b0100);
        chk("sub_op", int'(out_op), 2);
        sync();
        drain("drain_basic");

        // two overflow entries held with out_ready low
        out_ready = 1'b0;
        beat(2'b01, 4'b1011, 4'b0000, 1'b0, 1'b1);
        beat(2'b01, 4'b0000, 4'b0000, 1'b1, 1'b1);
        @(negedge clk);
        chk("hold_count", int'(fifo_count), 2);
        chk("hold_head_result", int'(out_result), 4'b1011);
        chk("hold_head_flags", int'(out_flags), 4'b1010);
        chk("sticky_set", int'(sticky_overflow), 1);
        sync();
        clear_sticky = 1'b1;
        sync();
        clear_sticky = 1'b0;
        @(negedge clk);
        chk("sticky_cleared", int'(sticky_overflow), 0);
        chk("hold_head_stable", int'(out_result), 4'b1011);
        sync();
        clear_sticky = 1'b1;
        beat(2'b01, 4'b1000, 4'b0000, 1'b0, 1'b1);
        clear_sticky = 1'b0;
        @(negedge clk);
        chk("sticky_set_wins", int'(sticky_overflow), 1);
        sync();
        clear_sticky = 1'b1;
        sync();
        clear_sticky = 1'b0;
        out_ready = 1'b1;
        drain("drain_ordered");
        chk("op_count_5", int'(op_count), STATS ? 5 : 0);

        // invalid opcodes
        beat(2'b00, 4'b0101, 4'b0101, 1'b0, 1'b0);
        @(negedge clk);
        chk("invalid_no_valid", int'(out_valid), 0);
        chk("drop_count_1", int'(drop_count), STATS ? 1 : 0);
        sync();
        beat(2'b11, 4'b0101, 4'b0101, 1'b0, 1'b1);
        @(negedge clk);
        chk("drop_count_2", int'(drop_count), STATS ? 2 : 0);
        chk("invalid_no_sticky", int'(sticky_overflow), 0);
        sync();

        // fill to DEPTH, then hold a fifth beat
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) beat(2'b01, 4'(i), 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_count", int'(fifo_count), 4);
        chk("full_in_ready", int'(in_ready), 0);
        sync();
        opCode = 2'b10; sub_Y = 4'b1111; add_Y = '0; CarryOUT = 1'b0; overflow = 1'b0;
        in_valid = 1'b1;
        repeat (2) sync();
        @(negedge clk);
        chk("full_held_count", int'(fifo_count), 4);
        sync();
        out_ready = 1'b1;
        sync();
        @(negedge clk);
        chk("reopen_in_ready", int'(in_ready), 1);
        chk("after_pop_count", int'(fifo_count), 3);
        sync();
        in_valid = 1'b0;
        begin
            exp_t e;
            e.op = 2'b10; e.result = 4'b1111; e.flags = 4'b0010;
            exp_q.push_back(e);
            n_ops++;
        end
        @(negedge clk);
        chk("push_pop_count", int'(fifo_count), 3);
        sync();
        drain("drain_full");
        chk("op_count_10", int'(op_count), STATS ? n_ops : 0);

        // drop counter saturation
        for (int i = 0; i < 260; i++) beat(2'b11, 4'b0000, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        chk("drop_saturated", int'(drop_count), STATS ? sat(n_drop) : 0);
        chk("op_count_unchanged", int'(op_count), STATS ? n_ops : 0);
        sync();

        // reset with entries in flight
        out_ready = 1'b0;
        beat(2'b01, 4'b0011, 4'b0000, 1'b0, 1'b1);
        beat(2'b10, 4'b0000, 4'b0110, 1'b1, 1'b0);
        reset = 1'b1;
        exp_q.delete();
        sync();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_count", int'(fifo_count), 0);
        chk("midrst_op_count", int'(op_count), 0);
        chk("midrst_drop_count", int'(drop_count), 0);
        chk("midrst_sticky", int'(sticky_overflow), 0);
        sync();
        out_ready = 1'b1;
        repeat (3) sync();
        @(negedge clk);
        chk("no_stale_entries", int'(out_valid), 0);
        sync();
        beat(2'b01, 4'b1100, 4'b0000, 1'b1, 1'b0);
        drain("drain_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "timeout");
    end

endmodule
